// File: rtl/arm_mem_responder_pkg.sv
// Shared types and defaults for the ARM core memory responder.
// Holds the responder state encoding, mailbox defaults and the word-index width helper.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_PASS_ADDR   = 32'd100;
    localparam logic [31:0] DEFAULT_PASS_VALUE  = 32'd7;
    localparam logic [31:0] DEFAULT_IGNORE_ADDR = 32'd96;

    function automatic int idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port word RAM: synchronous write, asynchronous read.
// The same address drives both the read and the write side.
module mem_ram #(
    parameter int unsigned DEPTH = 32'd64,
    parameter int          AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Word write on the rising edge; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the multicycle ARM core bus: image load port,
// wait-stated fetch/load/store service and a sticky pass/fail mailbox.
module arm_mem_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 32'd64,
    parameter int unsigned WAIT_STATES = 32'd0,
    parameter logic [31:0] PASS_ADDR   = DEFAULT_PASS_ADDR,
    parameter logic [31:0] PASS_VALUE  = DEFAULT_PASS_VALUE,
    parameter logic [31:0] IGNORE_ADDR = DEFAULT_IGNORE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    input  logic        LoadValid,
    input  logic [31:0] LoadData,
    input  logic        LoadLast,
    output logic        LoadReady,
    output logic        Done,
    output logic        Pass,
    output logic        Fail,
    output logic        AddrErr
);

    localparam int AW = idx_width(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [29:0]   widx_q, widx_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          oor_q, oor_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          aerr_q, aerr_d;

    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [31:0]   ram_wdata_s;
    logic [31:0]   ram_rdata_s;
    logic          unused_adr_s;

    assign unused_adr_s = ^Adr[1:0];

    mem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s && !reset),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Next-state logic for the FSM, wait counter, RAM port mux and mailbox.
    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        oor_d       = oor_q;
        ready_d     = 1'b0;
        rdata_d     = 32'h0000_0000;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        aerr_d      = aerr_q;
        ram_we_s    = 1'b0;
        ram_addr_s  = widx_q[AW-1:0];
        ram_wdata_s = wdata_q;

        case (state_q)
            S_LOAD: begin
                ram_addr_s  = load_ptr_q;
                ram_wdata_s = LoadData;
                if (LoadValid) begin
                    ram_we_s   = 1'b1;
                    load_ptr_d = load_ptr_q + AW'(1);
                    if (LoadLast || (load_ptr_q == AW'(DEPTH - 32'd1))) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_IDLE: begin
                if (MemReq) begin
                    widx_d  = Adr[31:2];
                    wr_d    = MemWrite;
                    wdata_d = WriteData;
                    oor_d   = ({2'b00, Adr[31:2]} >= 32'(DEPTH));
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
                if (oor_q) begin
                    aerr_d = 1'b1;
                end else begin
                    aerr_d = aerr_q;
                end
                // Only in-range stores commit and feed the mailbox; first event wins.
                if (wr_q && !oor_q) begin
                    ram_we_s = 1'b1;
                    if (done_q) begin
                        done_d = done_q;
                    end else if ((widx_q == PASS_ADDR[31:2]) && (wdata_q == PASS_VALUE)) begin
                        pass_d = 1'b1;
                        done_d = 1'b1;
                    end else if (widx_q == IGNORE_ADDR[31:2]) begin
                        done_d = done_q;
                    end else begin
                        fail_d = 1'b1;
                        done_d = 1'b1;
                    end
                end else if (!wr_q && !oor_q) begin
                    rdata_d = ram_rdata_s;
                end else begin
                    rdata_d = 32'h0000_0000;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            load_ptr_q <= '0;
            cnt_q      <= 4'd0;
            widx_q     <= 30'd0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            oor_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            cnt_q      <= cnt_d;
            widx_q     <= widx_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            oor_q      <= oor_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            aerr_q     <= aerr_d;
        end
    end

    assign ReadData  = rdata_q;
    assign MemReady  = ready_q;
    assign LoadReady = (state_q == S_LOAD);
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign Fail      = fail_q;
    assign AddrErr   = aerr_q;

endmodule

// File: doc/arm_mem_responder.md
# arm_mem_responder

Memory-side responder for the multicycle ARM core's unified instruction/data bus. It sits opposite the core's `Adr`/`WriteData`/`MemWrite` initiator port and serves fetches, loads and stores with a configurable number of wait states. It is preloaded through a streaming load port before the core is released. It also watches stores to a mailbox address and raises sticky pass/fail status for self-checking simulation and FPGA bring-up.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; power of two.
- `WAIT_STATES`, 0: extra cycles inserted before each response; range 0–15.
- `PASS_ADDR`, 100: byte address of the pass mailbox.
- `PASS_VALUE`, 7: store value at `PASS_ADDR` that signals pass.
- `IGNORE_ADDR`, 96: byte address whose stores never affect status.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemReq`  in  1  core requests a transfer.
- `MemWrite`  in  1  1 = store, 0 = read; qualified by `MemReq`.
- `Adr`  in  32  byte address; word index is `Adr[31:2]`, `Adr[1:0]` ignored.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  read data; valid while `MemReady`=1.
- `MemReady`  out  1  one-cycle response strobe.
- `LoadValid`  in  1  load beat valid.
- `LoadData`  in  32  load word.
- `LoadLast`  in  1  final beat of the image.
- `LoadReady`  out  1  high while in LOAD.
- `Done`  out  1  sticky; a pass or fail event has occurred.
- `Pass`  out  1  sticky pass.
- `Fail`  out  1  sticky fail.
- `AddrErr`  out  1  sticky; an access had word index ≥ `DEPTH`.

## Operation
States are LOAD, IDLE, BUSY and RESP.

**Reset**
- State goes to LOAD; `load_ptr`=0.
- `MemReady`, `ReadData`, `Done`, `Pass`, `Fail` and `AddrErr` all go to 0.
- RAM contents are not cleared.

**LOAD**
- `LoadReady`=1.
- Each `LoadValid` beat writes `LoadData` to RAM[`load_ptr`], then `load_ptr`++.
- The state goes to IDLE on a beat with `LoadLast`=1, or on the beat written at `load_ptr`=`DEPTH`-1.
- `MemReq` is ignored in LOAD.

**IDLE**
- If `MemReq`=1, latch `Adr`, `MemWrite` and `WriteData`, and load the counter with `WAIT_STATES`; go to BUSY.

**BUSY**
- Counter decrements each cycle.
- At counter 0, go to RESP.
- With `WAIT_STATES`=0, BUSY lasts exactly one cycle.

**RESP**
- `MemReady`=1 for exactly one cycle.
- Read: `ReadData` = RAM[latched index], or 0 if out of range.
- Write: commit to RAM at the RESP edge; `ReadData`=0.
- Always return to IDLE. `MemReq` is not sampled in RESP.

**Out of range** (index ≥ `DEPTH`)
- Reads return 0, writes are dropped, and `AddrErr` is set.

**Mailbox** (checked on committed writes only)
- Address == `PASS_ADDR` and data == `PASS_VALUE`: set `Pass` and `Done`.
- Address == `IGNORE_ADDR`: no status effect.
- Any other address, or `PASS_ADDR` with a different value: set `Fail` and `Done`.
- Status is first-event-wins: once `Done`=1, `Pass` and `Fail` freeze until reset.
- The RAM write still happens whatever the mailbox outcome.

**Core obligations**
- The core holds `MemReq` high until it sees `MemReady`, and drops it the following cycle.
- The responder latches request fields at acceptance, so later changes to the bus are ignored.

## Timing
- Latency from the `MemReq` sample in IDLE to `MemReady` is `WAIT_STATES`+2 cycles.
- Back-to-back throughput is one transfer per `WAIT_STATES`+3 cycles, because RESP always passes through one IDLE cycle.
- `ReadData` and `MemReady` are registered, and `ReadData` is valid only in the `MemReady` cycle.
- Status flags update on the edge after the RESP cycle.
- Load port: one beat per cycle, zero-bubble; `LoadReady` drops in the cycle after the last beat.
- Reset during BUSY or RESP drops the transfer: no write is committed, and `MemReady`=0 from the next cycle.

## Structure
- Shared package `arm_mem_pkg` holds:
  - the state enum (`S_LOAD`, `S_IDLE`, `S_BUSY`, `S_RESP`);
  - the default mailbox and ignore addresses;
  - the word-index width function `$clog2(DEPTH)`.
- Sub-module `mem_ram`: single-port word RAM with synchronous write and asynchronous read, shared by the load path and the core path. A mux on the load pointer selects the address in LOAD.
- The FSM, wait counter and mailbox checker live in the top module.

## Test plan
1. Load 4 words (0xE04F000F, 0xE2802005, 0xE280300C, 0xE2437009) with `LoadLast` on the 4th. Required: `LoadReady`=0 next cycle; a read at `Adr`=8 returns 0xE280300C, with `MemReady` exactly 2 cycles after `MemReq`.
2. `WAIT_STATES`=3; store 5 at `Adr`=96. Required: `MemReady` 5 cycles after the request; `Done`=0; a read back of 96 returns 5.
3. Store 7 at `Adr`=100. Required: `Done`=1 and `Pass`=1 on the cycle after RESP. A later store of 9 at `Adr`=60 leaves `Fail`=0.
4. Fresh reset, then store 3 at `Adr`=60. Required: `Done`=1, `Fail`=1, `Pass`=0; RAM[15]=3.
5. Read at `Adr`=`DEPTH`*4. Required: `ReadData`=0, `AddrErr`=1. A store 7 at `Adr`=`DEPTH`*4+100 also leaves RAM unchanged.
6. `WAIT_STATES`=4; assert reset in the 2nd BUSY cycle of a store. Required: `MemReady` never pulses, the RAM word is unchanged, and `LoadReady`=1 after reset.
